// File: rtl/board_pkg.sv
// Shared board geometry, cell/row types and the fetch FSM encoding used by
// the row fetch arbiter and its trigger generator.
package board_pkg;

   localparam int BOARD_W     = 10;   // cells per board row
   localparam int BOARD_H     = 20;   // rows per board
   localparam int SQUARE_SIZE = 21;   // scan lines per block row
   localparam int CELL_W      = 16;   // {R[11:8],G[7:4],B[3:0]} in [11:0]
   localparam int LAST_LINE   = 479;  // final visible DrawY

   localparam int ROW_BITS = 5;
   localparam int COL_BITS = 4;
   localparam int ADDR_W   = ROW_BITS + COL_BITS;

   typedef logic [CELL_W-1:0] cell_t;
   typedef cell_t [BOARD_W-1:0] row_t;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SWAP} fetch_state_t;

   // Board RAM address of one cell: row in the upper bits, column below.
   function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_BITS-1:0] row,
                                                   input logic [COL_BITS-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/row_trigger_gen.sv
// Rising-edge detect on hs plus the board row to prefetch for the next
// block row. The trigger pulses for one cycle on the hs edge only when the
// line after DrawY starts a new block row (or the frame has ended, which
// restarts at row 0).
module row_trigger_gen
   import board_pkg::*;
(
   input  logic                Clk,
   input  logic                reset_n,
   input  logic                hs,
   input  logic [9:0]          DrawY,
   output logic                trigger,
   output logic [ROW_BITS-1:0] target_row
);

   localparam logic [10:0] SQ_L   = 11'(SQUARE_SIZE);
   localparam logic [10:0] LAST_L = 11'(LAST_LINE);
   localparam logic [10:0] ROWS_L = 11'(BOARD_H);

   logic        hs_q;
   logic        hs_rise;
   logic [10:0] next_line;
   logic [10:0] quot;
   logic [10:0] rem;

   // Remember last cycle's hs so a rising edge is seen exactly once.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) hs_q <= 1'b0;
      else          hs_q <= hs;
   end

   assign hs_rise = hs & ~hs_q;

   // Decide whether this hs edge starts a fetch and which row it targets.
   // NOTE: every output of a combinational block gets a default first, so no latch can form.
   always_comb begin
      next_line  = {1'b0, DrawY} + 11'd1;
      quot       = next_line / SQ_L;
      rem        = next_line % SQ_L;
      trigger    = 1'b0;
      target_row = '0;
      if ({1'b0, DrawY} >= LAST_L) begin
         trigger    = hs_rise;
         target_row = '0;
      end else if ((rem == '0) && (quot < ROWS_L)) begin
         trigger    = hs_rise;
         target_row = quot[ROW_BITS-1:0];
      end
   end

endmodule

// File: rtl/row_fetch_arbiter.sv
// Row fetch arbiter: at each block-row boundary it reads the next board row
// from the shared single-port board RAM into a shadow buffer and swaps it
// into the display row buffer in one cycle. Game logic gets the RAM only
// while no fetch is in flight; display fetches always win.
// Optional build macro: ROWFETCH_OVERRUN_CNT_EN adds overrun_cnt, counting
// triggers lost to a busy fetch and excessively long game waits.
module row_fetch_arbiter
   import board_pkg::*;
(
   input  logic                Clk,
   input  logic                reset_n,
   input  logic                hs,
   input  logic [9:0]          DrawY,
   input  logic                game_req,
   input  logic                game_we,
   input  logic [ROW_BITS-1:0] game_row,
   input  logic [COL_BITS-1:0] game_col,
   input  cell_t               game_wdata,
   output logic                game_gnt,
   output logic                game_rvalid,
   output cell_t               game_rdata,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_we,
   output cell_t               mem_wdata,
   input  cell_t               mem_rdata,
   output row_t                Row,
   output logic [ROW_BITS-1:0] rowNum,
   output logic                row_valid
`ifdef ROWFETCH_OVERRUN_CNT_EN
   ,
   output logic [7:0]          overrun_cnt
`endif
);

   localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(BOARD_W - 1);

   fetch_state_t        state;
   fetch_state_t        state_d;
   logic                trigger;
   logic [ROW_BITS-1:0] trig_row;
   logic [ROW_BITS-1:0] target;
   logic [COL_BITS-1:0] col;
   row_t                shadow;
   logic                rd_pend;

   row_trigger_gen u_trig (
      .Clk        (Clk),
      .reset_n    (reset_n),
      .hs         (hs),
      .DrawY      (DrawY),
      .trigger    (trigger),
      .target_row (trig_row)
   );

   // FSM state register.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // FSM next state: a fetch runs IDLE -> FETCH x10 -> DRAIN -> SWAP -> IDLE.
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (trigger) state_d = FETCH;
         FETCH:   if (col == LAST_COL) state_d = DRAIN;
         DRAIN:   state_d = SWAP;
         SWAP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: RAM port mux. Game traffic only in IDLE and never in a
   // trigger cycle, so a fetch always sees a stable row.
   always_comb begin
      game_gnt  = 1'b0;
      mem_addr  = '0;
      mem_we    = 1'b0;
      mem_wdata = '0;
      case (state)
         IDLE: begin
            game_gnt  = game_req & ~trigger;
            mem_addr  = cell_addr(game_row, game_col);
            mem_we    = game_req & ~trigger & game_we;
            mem_wdata = game_wdata;
         end
         FETCH:   mem_addr = cell_addr(target, col);
         default: ;
      endcase
   end

   // Fetch datapath: column counter, shadow capture one cycle behind the
   // address, single-cycle swap, and the game read-return flag.
   // NOTE: the row buffers are reset here because a reset must blank the display row, not just the control.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         target    <= '0;
         col       <= '0;
         shadow    <= '0;
         Row       <= '0;
         rowNum    <= '0;
         row_valid <= 1'b0;
         rd_pend   <= 1'b0;
      end else begin
         rd_pend <= game_gnt & ~game_we;
         case (state)
            IDLE: begin
               if (trigger) begin
                  target <= trig_row;
                  col    <= '0;
               end
            end
            FETCH: begin
               if (col != '0)       shadow[col - 4'd1] <= mem_rdata;
               if (col != LAST_COL) col <= col + 4'd1;
            end
            DRAIN: shadow[BOARD_W-1] <= mem_rdata;
            SWAP: begin
               Row       <= shadow;
               rowNum    <= target;
               row_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // RAM read data arrives one cycle after the grant; pass it straight through.
   assign game_rvalid = rd_pend;
   assign game_rdata  = rd_pend ? mem_rdata : '0;

`ifdef ROWFETCH_OVERRUN_CNT_EN
   logic [4:0] wait_cnt;
   logic       denied;
   logic       lost_trig;
   logic       late_wait;
   logic [8:0] ovr_sum;
   logic [7:0] ovr_next;

   assign denied    = game_req & ~game_gnt;
   assign lost_trig = trigger & (state != IDLE);
   assign late_wait = denied & (wait_cnt >= 5'd16);

   // Saturating sum of this cycle's overrun events.
   always_comb begin
      ovr_sum  = {1'b0, overrun_cnt} + {8'd0, lost_trig} + {8'd0, late_wait};
      ovr_next = (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];
   end

   // Track consecutive denied game cycles and accumulate overruns.
   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt    <= '0;
         overrun_cnt <= '0;
      end else begin
         if (!denied)               wait_cnt <= '0;
         else if (wait_cnt != 5'd31) wait_cnt <= wait_cnt + 5'd1;
         overrun_cnt <= ovr_next;
      end
   end
`endif

endmodule

// File: tb/tb_row_fetch_arbiter.sv
// Testbench for row_fetch_arbiter: a board RAM model, a timing-window
// reference model that predicts grants, fetch addresses, row swaps and read
// returns, and a negedge monitor that checks the DUT against those queues.
`timescale 1ns/1ps
module tb_row_fetch_arbiter;
   import board_pkg::*;

   logic        Clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        hs = 1'b0;
   logic [9:0]  DrawY = '0;
   logic        game_req = 1'b0;
   logic        game_we = 1'b0;
   logic [4:0]  game_row = '0;
   logic [3:0]  game_col = '0;
   cell_t       game_wdata = '0;
   logic        game_gnt, game_rvalid;
   cell_t       game_rdata;
   logic [8:0]  mem_addr;
   logic        mem_we;
   cell_t       mem_wdata;
   cell_t       mem_rdata;
   row_t        Row;
   logic [4:0]  rowNum;
   logic        row_valid;
`ifdef ROWFETCH_OVERRUN_CNT_EN
   logic [7:0]  overrun_cnt;
`endif

   row_fetch_arbiter dut (
      .Clk         (Clk),
      .reset_n     (reset_n),
      .hs          (hs),
      .DrawY       (DrawY),
      .game_req    (game_req),
      .game_we     (game_we),
      .game_row    (game_row),
      .game_col    (game_col),
      .game_wdata  (game_wdata),
      .game_gnt    (game_gnt),
      .game_rvalid (game_rvalid),
      .game_rdata  (game_rdata),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .Row         (Row),
      .rowNum      (rowNum),
      .row_valid   (row_valid)
`ifdef ROWFETCH_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   always #5 Clk = ~Clk;

   // Board RAM: single port, one-cycle read latency, plus a preload port.
   cell_t      ram [512];
   logic       bd_we = 1'b0;
   logic [8:0] bd_addr = '0;
   cell_t      bd_data = '0;
   always @(posedge Clk) begin
      if (bd_we)       ram[bd_addr]  <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
   end

   int n_run = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model state (owned by the driver).
   cell_t      gold [512];
   int         cyc = 0;
   int         busy_end = 0;
   int         fetch_start = -100;
   logic [4:0] fetch_row = '0;
   logic       prev_hs = 1'b0;
   logic       exp_gnt = 1'b0;
   logic       exp_busy = 1'b0;
   logic       exp_fetch = 1'b0;
   logic [8:0] exp_addr = '0;
   logic       last_gnt = 1'b0;

   typedef struct { int due; cell_t data; } rd_item_t;
   typedef struct { int due; logic [4:0] row; row_t data; } sw_item_t;
   rd_item_t rd_q[$];
   sw_item_t sw_q[$];

   // Expected display state (owned by the monitor).
   row_t       exp_row = '0;
   logic [4:0] exp_num = '0;
   logic       exp_valid = 1'b0;

   // Predict this cycle's behaviour from the rules: a qualifying hs edge in
   // an idle window opens a 13-cycle busy window; otherwise game wins.
   task automatic model_eval();
      logic       trig;
      logic [4:0] tr;
      int         nl;
      row_t       snap;
      exp_gnt = 1'b0; exp_fetch = 1'b0; exp_busy = 1'b0; last_gnt = 1'b0;
      if (!reset_n) begin
         prev_hs = 1'b0;
         busy_end = cyc;
         return;
      end
      nl = int'(DrawY) + 1;
      trig = 1'b0; tr = '0;
      if (hs && !prev_hs) begin
         if (int'(DrawY) >= LAST_LINE) trig = 1'b1;
         else if ((nl % SQUARE_SIZE) == 0 && (nl / SQUARE_SIZE) < BOARD_H) begin
            trig = 1'b1;
            tr = 5'(nl / SQUARE_SIZE);
         end
      end
      prev_hs = hs;
      exp_busy = (cyc < busy_end);
      if (exp_busy && cyc > fetch_start && cyc <= fetch_start + BOARD_W) begin
         exp_fetch = 1'b1;
         exp_addr = {fetch_row, 4'(cyc - fetch_start - 1)};
      end
      if (!exp_busy) begin
         if (trig) begin
            fetch_start = cyc;
            busy_end = cyc + 13;
            fetch_row = tr;
            for (int c = 0; c < BOARD_W; c++) snap[c] = gold[{tr, 4'(c)}];
            sw_q.push_back('{cyc + 13, tr, snap});
         end else if (game_req) begin
            exp_gnt = 1'b1;
            last_gnt = 1'b1;
            if (game_we) gold[{game_row, game_col}] = game_wdata;
            else rd_q.push_back('{cyc + 1, gold[{game_row, game_col}]});
         end
      end
   endtask

   task automatic tick();
      model_eval();
      @(posedge Clk);
      #1;
      cyc++;
   endtask

   // Monitor: compare DUT outputs against the model between clock edges.
   always @(negedge Clk) begin
      logic exp_rv;
      if (!reset_n) begin
         rd_q.delete();
         sw_q.delete();
         exp_row = '0; exp_num = '0; exp_valid = 1'b0;
         check("rst_row", 160'(Row), 160'(0));
         check("rst_row_valid", 160'(row_valid), 160'(0));
         check("rst_rvalid", 160'(game_rvalid), 160'(0));
         check("rst_mem_we", 160'(mem_we), 160'(0));
      end else begin
         if (sw_q.size() > 0 && sw_q[0].due == cyc) begin
            exp_row = sw_q[0].data;
            exp_num = sw_q[0].row;
            exp_valid = 1'b1;
            void'(sw_q.pop_front());
         end
         check("Row", 160'(Row), 160'(exp_row));
         check("rowNum", 160'(rowNum), 160'(exp_num));
         check("row_valid", 160'(row_valid), 160'(exp_valid));
         check("game_gnt", 160'(game_gnt), 160'(exp_gnt));
         check("mem_we", 160'(mem_we), 160'(exp_gnt && game_we));
         if (exp_fetch) check("fetch_addr", 160'(mem_addr), 160'(exp_addr));
         if (exp_gnt) begin
            check("game_addr", 160'(mem_addr), 160'({game_row, game_col}));
            if (game_we) check("game_wdata", 160'(mem_wdata), 160'(game_wdata));
         end
         exp_rv = (rd_q.size() > 0 && rd_q[0].due == cyc);
         check("game_rvalid", 160'(game_rvalid), 160'(exp_rv));
         if (exp_rv) begin
            check("game_rdata", 160'(game_rdata), 160'(rd_q[0].data));
            void'(rd_q.pop_front());
         end else begin
            check("game_rdata_idle", 160'(game_rdata), 160'(0));
         end
      end
   end

   task automatic do_reset(input int n);
      reset_n = 1'b0; hs = 1'b0; game_req = 1'b0;
      repeat (n) tick();
      reset_n = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic hs_pulse(input logic [9:0] dy, input int hi);
      DrawY = dy; hs = 1'b1;
      repeat (hi) tick();
      hs = 1'b0;
   endtask

   // Hold a game request until the model grants it (bounded).
   task automatic game_access(input logic we, input logic [4:0] r, input logic [3:0] c,
                              input cell_t d);
      game_req = 1'b1; game_we = we; game_row = r; game_col = c; game_wdata = d;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (last_gnt) break;
      end
      game_req = 1'b0;
   endtask

   task automatic check_row3(input string tag);
      for (int c = 0; c < BOARD_W; c++)
         check(tag, 160'(Row[c]), 160'(16'h0F00 + 16'(c)));
      check({tag, "_num"}, 160'(rowNum), 160'(3));
   endtask

   initial begin
      // Reset while preloading RAM and the golden board.
      reset_n = 1'b0;
      for (int i = 0; i < 512; i++) begin
         bd_we = 1'b1;
         bd_addr = 9'(i);
         bd_data = (i[8:4] == 5'd3) ? cell_t'(16'h0F00 + 16'(i[3:0])) : cell_t'($urandom);
         gold[i] = bd_data;
         tick();
      end
      bd_we = 1'b0;
      tick();
      check("rst_mem_addr", 160'(mem_addr), 160'(0));
      check("rst_gnt", 160'(game_gnt), 160'(0));
      check("rst_rowNum", 160'(rowNum), 160'(0));
      reset_n = 1'b1;
      idle(3);

      // Row 3 fetch from DrawY=62.
      hs_pulse(10'd62, 3);
      idle(12);
      check_row3("row3");
      check("row3_valid", 160'(row_valid), 160'(1));

`ifdef ROWFETCH_OVERRUN_CNT_EN
      // Second hs edge at T+4 while fetching: counted, fetch unchanged.
      DrawY = 10'd62; hs = 1'b1; tick(); tick();
      hs = 1'b0; tick(); tick();
      hs = 1'b1; tick();
      hs = 1'b0;
      idle(12);
      check("overrun_cnt", 160'(overrun_cnt), 160'(1));
      check_row3("ovr_row3");
`endif

      // End of frame -> row 0.
      hs_pulse(10'd479, 2);
      idle(14);
      check("frame_end_num", 160'(rowNum), 160'(0));

      // DrawY=63: no fetch, game read granted immediately.
      DrawY = 10'd63; hs = 1'b1;
      game_access(1'b0, 5'd9, 4'd1, '0);
      hs = 1'b0;
      idle(3);

      // Game read in the trigger cycle: waits for the whole fetch.
      DrawY = 10'd20; hs = 1'b1;
      game_access(1'b0, 5'd5, 4'd2, '0);
      hs = 1'b0;
      idle(3);

      // Game write then fetch of that row.
      game_access(1'b1, 5'd7, 4'd4, 16'h0ABC);
      idle(2);
      hs_pulse(10'd146, 2);
      idle(14);
      check("write_seen", 160'(Row[4]), 160'(16'h0ABC));
      check("write_row", 160'(rowNum), 160'(7));

      // Reset in the middle of a fetch, then a clean fetch.
      DrawY = 10'd62; hs = 1'b1; tick(); tick();
      hs = 1'b0; tick(); tick(); tick();
      do_reset(2);
      check("midrst_row", 160'(Row), 160'(0));
      check("midrst_valid", 160'(row_valid), 160'(0));
      idle(2);
      hs_pulse(10'd62, 2);
      idle(14);
      check_row3("after_rst");

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         if (last_gnt) game_req = 1'b0;
         if (!game_req && $urandom_range(0, 2) == 0) begin
            game_req = 1'b1;
            game_we = 1'($urandom_range(0, 1));
            game_row = 5'($urandom_range(0, 19));
            game_col = 4'($urandom_range(0, 9));
            game_wdata = cell_t'($urandom);
         end
         if ($urandom_range(0, 9) == 0) begin
            if (!hs) begin
               case ($urandom_range(0, 2))
                  0:       DrawY = 10'(21 * $urandom_range(1, 19) - 1);
                  1:       DrawY = 10'($urandom_range(479, 1023));
                  default: DrawY = 10'($urandom_range(0, 1023));
               endcase
            end
            hs = ~hs;
         end
         if ($urandom_range(0, 999) == 0) do_reset(1);
         tick();
      end
      game_req = 1'b0; hs = 1'b0;
      idle(20);
      check("reads_left", 160'(rd_q.size()), 160'(0));
      check("swaps_left", 160'(sw_q.size()), 160'(0));

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
